calc_sequencer: RTL and testbench

Control sequencer for the four-function calculator. It sits between the keypad decoder and the arithmetic unit. It assembles decimal key presses into the two 9-bit operands, latches the operator, and launches the ALU with a start/done handshake. It then holds the result for display and supports chaining a new operation onto the previous result.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/operand_accumulator.sv | 29 ++
 rtl/calc_sequencer.sv | 143 ++++++++++++++
 tb/tb_calc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: states, key codes,
// ALU op encoding and datapath widths.
package calc_pkg;

  localparam int OPND_W = 9;
  localparam int RES_W  = 19;
  localparam logic [OPND_W-1:0] OPND_MAX = 9'd511;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPA      = 3'd1,
    ST_OPERATOR = 3'd2,
    ST_OPB      = 3'd3,
    ST_EXEC     = 3'd4,
    ST_WAIT     = 3'd5,
    ST_RESULT   = 3'd6,
    ST_ERROR    = 3'd7
  } state_e;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // Operator keys 10..13 map in order onto op codes 0..3.
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    return 2'(code - KEY_ADD);
  endfunction

endpackage

// File: rtl/operand_accumulator.sv
// One decimal operand register: clear, parallel load, or shift-in of a
// decimal digit (x10 + d). A digit that would push the value past 511 is
// discarded and the register keeps its old value.
module operand_accumulator
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [OPND_W-1:0] load_val,
  input  logic              accum,
  input  logic [3:0]        digit,
  output logic [OPND_W-1:0] value
);

  // 511*10+9 = 5119 fits in 13 bits, so the bound test sees the true value.
  logic [12:0] acc_next;
  assign acc_next = 13'(value) * 13'd10 + 13'(digit);

  // Operand register; clear beats load beats accumulate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 value <= '0;
    else if (clear)                             value <= '0;
    else if (load)                              value <= load_val;
    else if (accum && acc_next <= 13'(OPND_MAX)) value <= acc_next[OPND_W-1:0];
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: assembles keypad digits into two operands,
// latches the operator, launches the ALU with a start/done handshake,
// holds the result and lets a new operation chain onto it.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [8:0]  OperandA,
  output logic [8:0]  OperandB,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [18:0] alu_result,
  output logic [18:0] result,
  output logic        result_valid,
  output logic        error,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_OPA      = ST_OPA;
  localparam logic [2:0] S_OPERATOR = ST_OPERATOR;
  localparam logic [2:0] S_OPB      = ST_OPB;
  localparam logic [2:0] S_EXEC     = ST_EXEC;
  localparam logic [2:0] S_WAIT     = ST_WAIT;
  localparam logic [2:0] S_RESULT   = ST_RESULT;
  localparam logic [2:0] S_ERROR    = ST_ERROR;

  logic [2:0] nxt_state;
  logic [7:0] tmo_cnt;
  logic       pend_vld;
  logic [1:0] pend_op;

  logic       is_clr, is_dig, is_op, is_eq;
  logic [1:0] key_op, eff_op;
  logic       div0, tmo_hit, res_ok;

  logic       a_clr, a_ld, a_acc, b_clr, b_ld, b_acc;
  logic [8:0] a_ldv;
  logic       op_ld, res_ld, pend_set, pend_clr;

  assign key_ready    = (state != S_EXEC) && (state != S_WAIT);
  assign result_valid = (state == S_RESULT);
  assign error        = (state == S_ERROR);

  // Clear bypasses key_ready so the user can always abort.
  assign is_clr = key_valid && (key_code == KEY_CLR);
  assign is_dig = key_valid && key_ready && (key_code <= 4'd9);
  assign is_op  = key_valid && key_ready && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign is_eq  = key_valid && key_ready && (key_code == KEY_EQ);
  assign key_op = key_to_op(key_code);
  // A pending chained operator stands in for a real key while in RESULT.
  assign eff_op = pend_vld ? pend_op : key_op;

  assign div0      = (alu_op == OP_DIV) && (OperandB == '0);
  assign alu_start = (state == S_EXEC) && !div0;
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign res_ok    = (result[18:9] == '0);

  // Next-state and datapath control decode.
  always_comb begin
    nxt_state = state;
    a_clr = 1'b0; a_ld = 1'b0; a_acc = 1'b0; a_ldv = {5'b0, key_code};
    b_clr = 1'b0; b_ld = 1'b0; b_acc = 1'b0;
    op_ld = 1'b0; res_ld = 1'b0; pend_set = 1'b0; pend_clr = 1'b0;
    if (is_clr) begin
      nxt_state = S_IDLE;
      a_clr = 1'b1; b_clr = 1'b1; pend_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE:
          if (is_dig) begin a_ld = 1'b1; nxt_state = S_OPA; end
        S_OPA:
          if (is_dig)     a_acc = 1'b1;
          else if (is_op) begin op_ld = 1'b1; nxt_state = S_OPERATOR; end
        S_OPERATOR:
          if (is_op)       op_ld = 1'b1;
          else if (is_dig) begin b_ld = 1'b1; nxt_state = S_OPB; end
        S_OPB:
          if (is_dig)     b_acc = 1'b1;
          else if (is_eq) nxt_state = S_EXEC;
          else if (is_op) begin pend_set = 1'b1; nxt_state = S_EXEC; end
        S_EXEC:
          nxt_state = div0 ? S_ERROR : S_WAIT;
        S_WAIT:
          if (alu_done)     begin res_ld = 1'b1; nxt_state = S_RESULT; end
          else if (tmo_hit) nxt_state = S_ERROR;
        S_RESULT:
          if (pend_vld || is_op) begin
            pend_clr = 1'b1;
            if (res_ok) begin
              a_ld = 1'b1; a_ldv = result[8:0]; b_clr = 1'b1; op_ld = 1'b1;
              nxt_state = S_OPERATOR;
            end else begin
              nxt_state = S_ERROR;
            end
          end else if (is_dig) begin
            a_ld = 1'b1; b_clr = 1'b1; nxt_state = S_OPA;
          end
        default: ;
      endcase
    end
  end

  // State, op, result, chained-op and timeout registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      alu_op   <= '0;
      result   <= '0;
      pend_vld <= 1'b0;
      pend_op  <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= nxt_state;
      if (is_clr)     alu_op <= '0;
      else if (op_ld) alu_op <= eff_op;
      if (is_clr)      result <= '0;
      else if (res_ld) result <= alu_result;
      if (pend_clr)      pend_vld <= 1'b0;
      else if (pend_set) begin pend_vld <= 1'b1; pend_op <= key_op; end
      if (state == S_EXEC)      tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  operand_accumulator u_opa (
    .clk(clk), .reset(reset), .clear(a_clr), .load(a_ld), .load_val(a_ldv),
    .accum(a_acc), .digit(key_code), .value(OperandA)
  );

  operand_accumulator u_opb (
    .clk(clk), .reset(reset), .clear(b_clr), .load(b_ld), .load_val({5'b0, key_code}),
    .accum(b_acc), .digit(key_code), .value(OperandB)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected ALU launches,
// results and error entries; a monitor pops them as the DUT produces them.
module tb_calc_sequencer;

  localparam int T = 10;

  logic        clk = 1'b0, reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        key_ready, alu_start, alu_done = 1'b0;
  logic [8:0]  OperandA, OperandB;
  logic [1:0]  alu_op;
  logic [18:0] alu_result = '0, result;
  logic        result_valid, error;
  logic [2:0]  state;

  calc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .OperandA(OperandA), .OperandB(OperandB),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { int kind; logic [31:0] val; } ev_t;
  localparam int EV_START = 1, EV_RESULT = 2, EV_ERROR = 3;
  ev_t exp_q[$];

  int          alu_lat  = 1;
  logic [18:0] alu_res  = '0;
  bit          alu_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ev_start(input logic [8:0] a, input logic [8:0] b, input logic [1:0] op);
    return {12'b0, a, b, op};
  endfunction

  function automatic void push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endfunction

  function automatic logic [3:0] key_of(input byte ch);
    case (ch)
      "+": return 4'd10;
      "-": return 4'd11;
      "*": return 4'd12;
      "/": return 4'd13;
      "=": return 4'd14;
      "C": return 4'd15;
      default: return 4'(ch - 8'd48);
    endcase
  endfunction

  // Called at posedge+1; each key is one strobe cycle, back to back.
  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      key_valid = 1'b1; key_code = key_of(s[i]);
      @(posedge clk); #1;
      key_valid = 1'b0;
    end
  endtask

  task automatic wait_rv(input int max);
    for (int i = 0; i < max; i++) begin
      if (result_valid) break;
      @(posedge clk); #1;
    end
    chk("result_valid_seen", 32'(result_valid), 32'd1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_state"}, 32'(state), 32'd0);
    chk({nm, "_opa"}, 32'(OperandA), 32'd0);
    chk({nm, "_opb"}, 32'(OperandB), 32'd0);
    chk({nm, "_op"}, 32'(alu_op), 32'd0);
    chk({nm, "_result"}, 32'(result), 32'd0);
    chk({nm, "_flags"}, {29'b0, alu_start, result_valid, error}, 32'd0);
  endtask

  // ALU model: answers each launch after alu_lat cycles unless held off.
  initial forever begin
    @(negedge clk);
    if (reset && alu_start && !alu_hold) begin
      repeat (alu_lat) @(posedge clk);
      #1 alu_done = 1'b1; alu_result = alu_res;
      @(posedge clk);
      #1 alu_done = 1'b0; alu_result = '0;
    end
  end

  // Monitor: pops an expected entry for each launch, result and error entry.
  initial begin
    logic rv_q, err_q;
    rv_q = 1'b0; err_q = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start) mon_pop("start", EV_START, ev_start(OperandA, OperandB, alu_op));
      if (result_valid && !rv_q) mon_pop("result", EV_RESULT, 32'(result));
      if (error && !err_q) mon_pop("error", EV_ERROR, 32'd0);
      rv_q = result_valid; err_q = error;
    end
  end

  task automatic mon_pop(input string nm, input int kind, input logic [31:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s actual=%0h required=none", nm, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        failures++;
        $display("FAIL sb_%s actual=%0d/%0h required=%0d/%0h", nm, kind, val, e.kind, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_idle("reset");
    chk("reset_key_ready", 32'(key_ready), 32'd1);

    // 123 + 45 = 168, ALU answers on its 3rd cycle
    alu_lat = 3; alu_res = 19'd168;
    push(EV_START, ev_start(9'd123, 9'd45, 2'd0)); push(EV_RESULT, 32'd168);
    keys("123+");
    chk("t1_operator_state", 32'(state), 32'd2);
    chk("t1_opa", 32'(OperandA), 32'd123);
    keys("45=");
    chk("t1_exec_state", 32'(state), 32'd4);
    chk("t1_opb", 32'(OperandB), 32'd45);
    wait_rv(20);
    chk("t1_result", 32'(result), 32'd168);
    keys("C");
    chk_idle("t1_clr");

    // overflow bound: 512 discarded, 511 kept, 5110 discarded
    keys("512");
    chk("t2_opa_51", 32'(OperandA), 32'd51);
    keys("1");
    chk("t2_opa_511", 32'(OperandA), 32'd511);
    keys("0");
    chk("t2_opa_hold", 32'(OperandA), 32'd511);
    chk("t2_state", 32'(state), 32'd1);
    keys("C");

    // divide by zero: no launch, straight to ERROR
    push(EV_ERROR, 32'd0);
    keys("7/0=");
    chk("t3_exec_state", 32'(state), 32'd4);
    chk("t3_no_start", 32'(alu_start), 32'd0);
    @(posedge clk); #1;
    chk("t3_error_state", 32'(state), 32'd7);
    chk("t3_error", 32'(error), 32'd1);
    keys("5+=");
    chk("t3_stuck", 32'(state), 32'd7);
    keys("C");
    chk_idle("t3_clr");

    // chained: 9-2 = 7, pending * applied, then 7*3 = 21
    alu_lat = 2; alu_res = 19'd7;
    push(EV_START, ev_start(9'd9, 9'd2, 2'd1)); push(EV_RESULT, 32'd7);
    keys("9-2*");
    wait_rv(20);
    chk("t4_result7", 32'(result), 32'd7);
    @(posedge clk); #1;
    chk("t4_chain_state", 32'(state), 32'd2);
    chk("t4_chain_opa", 32'(OperandA), 32'd7);
    chk("t4_chain_op", 32'(alu_op), 32'd2);
    chk("t4_chain_opb", 32'(OperandB), 32'd0);
    alu_res = 19'd21;
    push(EV_START, ev_start(9'd7, 9'd3, 2'd2)); push(EV_RESULT, 32'd21);
    keys("3=");
    wait_rv(20);
    chk("t4_result21", 32'(result), 32'd21);
    keys("C");

    // negative result then operator -> ERROR
    alu_lat = 1; alu_res = 19'h7FFFD;
    push(EV_START, ev_start(9'd2, 9'd5, 2'd1)); push(EV_RESULT, 32'h7FFFD); push(EV_ERROR, 32'd0);
    keys("2-5=");
    wait_rv(20);
    chk("t5_neg_result", 32'(result), 32'h7FFFD);
    keys("+");
    chk("t5_range_err", 32'(state), 32'd7);
    keys("C");

    // timeout: exactly T cycles in WAIT, then ERROR
    alu_hold = 1'b1;
    push(EV_START, ev_start(9'd4, 9'd4, 2'd0)); push(EV_ERROR, 32'd0);
    keys("4+4=");
    for (int k = 1; k <= T; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("t6_wait_key_ready", 32'(key_ready), 32'd0);
    end
    chk("t6_last_wait", 32'(state), 32'd5);
    @(posedge clk); #1;
    chk("t6_timeout_state", 32'(state), 32'd7);
    keys("C");
    chk_idle("t6_clr");
    alu_hold = 1'b0;

    // done on the last WAIT cycle beats the timeout
    alu_lat = T; alu_res = 19'd8;
    push(EV_START, ev_start(9'd4, 9'd4, 2'd0)); push(EV_RESULT, 32'd8);
    keys("4+4=");
    wait_rv(T + 5);
    chk("t7_done_wins", 32'(state), 32'd6);
    chk("t7_result", 32'(result), 32'd8);
    keys("C");

    // clear during WAIT; digit dropped; late done ignored
    alu_lat = 5; alu_res = 19'd99;
    push(EV_START, ev_start(9'd6, 9'd6, 2'd2));
    keys("6*6=");
    @(posedge clk); #1;
    keys("3");
    chk("t8_digit_dropped", 32'(OperandB), 32'd6);
    chk("t8_still_wait", 32'(state), 32'd5);
    keys("C");
    chk_idle("t8_clr");
    repeat (6) @(posedge clk);
    #1;
    chk("t8_late_state", 32'(state), 32'd0);
    chk("t8_late_result", 32'(result), 32'd0);

    // async reset in the middle of WAIT
    alu_hold = 1'b1;
    push(EV_START, ev_start(9'd3, 9'd3, 2'd0));
    keys("3+3=");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t9_wait", 32'(state), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk_idle("t9_async");
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t9_post_state", 32'(state), 32'd0);
    chk("t9_post_key_ready", 32'(key_ready), 32'd1);
    alu_hold = 1'b0;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
